hynoc_local_egress_reader: RTL and testbench
============================================

// Module: hynoc_local_egress_reader
//
// PURPOSE
//   Local-side consumer of the HyNoC local interface egress FIFO (FWFT read/data/empty).
//   Pops flits, separates each packet's header flit from its payload flits.
//   Presents the payload on a registered valid/ready stream with a last marker.
//   Enforces a maximum payload length and drops the excess flits of overlong packets.
//   Sits between hynoc_local_interface (local_egress_*) and the local IP core.
//
// PARAMETERS
//   FLIT_WIDTH        33  flit width; bit FLIT_WIDTH-1 = end-of-packet, [FLIT_WIDTH-2:0] = data
//   LOG2_FIFO_DEPTH   5   matches the local interface FIFO; sizes fifo_level input
//   LOG2_MAX_PAYLOAD  8   max payload flits per packet = 2**LOG2_MAX_PAYLOAD
//
// PORTS
//   local_clk          in   1                  clock
//   local_arst_n       in   1                  asynchronous reset, active low
//   egress_read        out  1                  pop strobe to local_egress_read
//   egress_data        in   FLIT_WIDTH         head flit (valid while !egress_empty)
//   egress_empty       in   1                  FIFO empty
//   egress_fifo_level  in   LOG2_FIFO_DEPTH+1  FIFO occupancy (status only, not used for flow)
//   hdr_valid          out  1                  one-cycle pulse: header captured
//   hdr_data           out  FLIT_WIDTH-1       header payload bits, held until next header
//   out_valid          out  1                  payload flit available
//   out_ready          in   1                  consumer accepts when out_valid & out_ready
//   out_data           out  FLIT_WIDTH-1       payload data
//   out_last           out  1                  last payload flit of packet (or truncation point)
//   err_overlong       out  1                  one-cycle pulse: packet exceeded max, truncated
//
// BEHAVIOUR
//   - Reset (async assert, sync release): every output 0, state HDR, payload count 0.
//   - egress_read is combinational: !egress_empty & pop_allowed. It is never asserted while empty.
//   - FSM states and pop_allowed:
//     HDR:     pop_allowed = 1. The popped flit goes to hdr_data and hdr_valid=1 on the next cycle.
//              last=1 (header-only packet) -> stay in HDR. last=0 -> PAYLOAD, count cleared.
//     PAYLOAD: pop_allowed = !out_valid | out_ready.
//              The popped flit loads out_data/out_last and sets out_valid on the next cycle.
//              Count increments on every payload pop.
//              last=1 -> HDR.
//              last=0 with count reaching 2**LOG2_MAX_PAYLOAD -> force out_last=1,
//              pulse err_overlong, go to DROP.
//     DROP:    pop_allowed = 1. Flits are discarded.
//              The flit with last=1 -> HDR. No out_valid and no hdr_valid while in DROP.
//   - Latency: 1 cycle from pop to hdr_valid/out_valid. Sustained 1 flit/cycle with out_ready=1.
//   - out_valid stays high, with out_data/out_last stable, until accepted.
//     A simultaneous accept and pop replaces the flit with no bubble.
//   - out_valid clears on accept when no new pop occurs in that cycle.
//   - A header pop is allowed while the last payload flit of the previous packet is still pending.
//   - Reset mid-packet: the partial packet state is discarded.
//     After release, the first flit popped is treated as a header.
//
// CONFIGURATION
//   HYNOC_EGRESS_READER_STATS_EN defined:
//     - adds outputs stat_pkt_count[31:0] and stat_drop_count[31:0].
//     - stat_pkt_count increments on each hdr_valid.
//     - stat_drop_count increments on each flit discarded in DROP.
//     - both counters wrap at 2**32 and reset to 0.
//   Not defined: these ports and counters are absent; the rest of the behaviour is identical.
//
// TESTING (FLIT_WIDTH=33, LOG2_MAX_PAYLOAD=2)
//   1. FIFO holds 0_00000A01, 0_00000011, 1_00000022; out_ready=1
//      -> hdr_data=0x00000A01 pulse; out 0x11 (last=0), 0x22 (last=1); back in HDR.
//   2. Header-only 1_0000BEEF
//      -> hdr_valid with 0x0000BEEF; no out_valid; next flit is treated as a header.
//   3. Header + payload 0x1..0x6, the 6th flit with last=1
//      -> out 0x1..0x4, 0x4 with out_last=1; err_overlong pulses once; 0x5 and 0x6 are dropped.
//   4. out_ready=0 for 5 cycles during a payload
//      -> out_data held; egress_read=0; no flit lost or duplicated after out_ready=1.
//   5. egress_empty toggles randomly over 200 packets of random length 0..3
//      -> output sequence equals the input sequence; egress_read is never asserted while empty.
//   6. local_arst_n pulsed low mid-payload
//      -> all outputs 0 immediately; the next popped flit produces hdr_valid.

Source files
------------

// File: rtl/hynoc_local_egress_reader.sv
// Local-side reader for the HyNoC egress FIFO: splits header/payload, streams payload with last marker.
// Optional statistics counters are enabled by defining HYNOC_EGRESS_READER_STATS_EN.
module hynoc_local_egress_reader #(
  parameter int unsigned FLIT_WIDTH       = 33,
  parameter int unsigned LOG2_FIFO_DEPTH  = 5,
  parameter int unsigned LOG2_MAX_PAYLOAD = 8
) (
  input  logic                       local_clk,
  input  logic                       local_arst_n,
  output logic                       egress_read,
  input  logic [FLIT_WIDTH-1:0]      egress_data,
  input  logic                       egress_empty,
  input  logic [LOG2_FIFO_DEPTH:0]   egress_fifo_level,
  output logic                       hdr_valid,
  output logic [FLIT_WIDTH-2:0]      hdr_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FLIT_WIDTH-2:0]      out_data,
  output logic                       out_last,
  output logic                       err_overlong
`ifdef HYNOC_EGRESS_READER_STATS_EN
  ,
  output logic [31:0]                stat_pkt_count,
  output logic [31:0]                stat_drop_count
`endif
);

  localparam int unsigned DATA_W      = FLIT_WIDTH - 1;
  localparam int unsigned CNT_W       = LOG2_MAX_PAYLOAD + 1;
  localparam int unsigned MAX_PAYLOAD = 2 ** LOG2_MAX_PAYLOAD;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_rst_done;
  logic                r_hdr_valid;
  logic [DATA_W-1:0]   r_hdr_data;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_last;
  logic                r_err_overlong;
  logic [CNT_W-1:0]    r_count;

  logic                w_hdr_valid_nxt;
  logic [DATA_W-1:0]   w_hdr_data_nxt;
  logic                w_out_valid_nxt;
  logic [DATA_W-1:0]   w_out_data_nxt;
  logic                w_out_last_nxt;
  logic                w_err_nxt;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [CNT_W-1:0]    w_count_inc;
  logic                w_drop;

  logic                w_pop_allowed;
  logic                w_pop;
  logic                w_flit_last;
  logic [DATA_W-1:0]   w_flit_data;
  logic                w_unused_level;

  // Occupancy is informational only; flow control relies on egress_empty.
  assign w_unused_level = ^egress_fifo_level;

  assign w_flit_last = egress_data[FLIT_WIDTH-1];
  assign w_flit_data = egress_data[FLIT_WIDTH-2:0];
  assign w_count_inc = r_count + CNT_W'(1);

  // Payload pops wait for the output slot; header and drop pops never stall.
  assign w_pop_allowed = (r_state == ST_PAYLOAD) ? (~r_out_valid | out_ready) : 1'b1;
  // r_rst_done keeps the FIFO untouched while reset is asserted.
  assign w_pop         = r_rst_done & ~egress_empty & w_pop_allowed;
  assign egress_read   = w_pop;

  always_ff @(posedge local_clk or negedge local_arst_n) begin
    if (!local_arst_n) begin
      r_state        <= ST_HDR;
      r_rst_done     <= 1'b0;
      r_hdr_valid    <= 1'b0;
      r_hdr_data     <= '0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_last     <= 1'b0;
      r_err_overlong <= 1'b0;
      r_count        <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_rst_done     <= 1'b1;
      r_hdr_valid    <= w_hdr_valid_nxt;
      r_hdr_data     <= w_hdr_data_nxt;
      r_out_valid    <= w_out_valid_nxt;
      r_out_data     <= w_out_data_nxt;
      r_out_last     <= w_out_last_nxt;
      r_err_overlong <= w_err_nxt;
      r_count        <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_hdr_valid_nxt = 1'b0;
    w_hdr_data_nxt  = r_hdr_data;
    w_out_valid_nxt = r_out_valid & ~out_ready;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    w_err_nxt       = 1'b0;
    w_count_nxt     = r_count;
    w_drop          = 1'b0;

    case (r_state)
      ST_HDR: begin
        if (w_pop) begin
          w_hdr_valid_nxt = 1'b1;
          w_hdr_data_nxt  = w_flit_data;
          if (!w_flit_last) begin
            w_state_nxt = ST_PAYLOAD;
            w_count_nxt = '0;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_pop) begin
          w_count_nxt     = w_count_inc;
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = w_flit_data;
          w_out_last_nxt  = w_flit_last;
          if (w_flit_last) begin
            w_state_nxt = ST_HDR;
          end else if (w_count_inc == CNT_W'(MAX_PAYLOAD)) begin
            // Truncate: close the packet here and swallow the rest.
            w_out_last_nxt = 1'b1;
            w_err_nxt      = 1'b1;
            w_state_nxt    = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (w_pop) begin
          w_drop = 1'b1;
          if (w_flit_last) begin
            w_state_nxt = ST_HDR;
          end
        end
      end
      default: begin
        w_state_nxt = ST_HDR;
      end
    endcase
  end

  assign hdr_valid    = r_hdr_valid;
  assign hdr_data     = r_hdr_data;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_last     = r_out_last;
  assign err_overlong = r_err_overlong;

`ifdef HYNOC_EGRESS_READER_STATS_EN
  logic [31:0] r_stat_pkt;
  logic [31:0] r_stat_drop;

  // Free-running wrap-around counters of headers seen and flits discarded.
  always_ff @(posedge local_clk or negedge local_arst_n) begin
    if (!local_arst_n) begin
      r_stat_pkt  <= '0;
      r_stat_drop <= '0;
    end else begin
      if (r_hdr_valid) begin
        r_stat_pkt <= r_stat_pkt + 32'd1;
      end
      if (w_drop) begin
        r_stat_drop <= r_stat_drop + 32'd1;
      end
    end
  end

  assign stat_pkt_count  = r_stat_pkt;
  assign stat_drop_count = r_stat_drop;
`endif

endmodule

// File: tb/tb_hynoc_local_egress_reader.sv
// Scoreboard bench for hynoc_local_egress_reader with a small max payload (4 flits).
module tb_hynoc_local_egress_reader;

  localparam int FW   = 33;
  localparam int LFD  = 5;
  localparam int LMP  = 2;
  localparam int DW   = FW - 1;
  localparam int MAXP = 4;

  logic              local_clk = 1'b0;
  logic              local_arst_n;
  logic              egress_read;
  logic [FW-1:0]     egress_data;
  logic              egress_empty;
  logic [LFD:0]      egress_fifo_level;
  logic              hdr_valid;
  logic [DW-1:0]     hdr_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              err_overlong;
`ifdef HYNOC_EGRESS_READER_STATS_EN
  logic [31:0]       stat_pkt_count;
  logic [31:0]       stat_drop_count;
`endif

  hynoc_local_egress_reader #(
    .FLIT_WIDTH       (FW),
    .LOG2_FIFO_DEPTH  (LFD),
    .LOG2_MAX_PAYLOAD (LMP)
  ) dut (
    .local_clk         (local_clk),
    .local_arst_n      (local_arst_n),
    .egress_read       (egress_read),
    .egress_data       (egress_data),
    .egress_empty      (egress_empty),
    .egress_fifo_level (egress_fifo_level),
    .hdr_valid         (hdr_valid),
    .hdr_data          (hdr_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_last          (out_last),
    .err_overlong      (err_overlong)
`ifdef HYNOC_EGRESS_READER_STATS_EN
    ,
    .stat_pkt_count    (stat_pkt_count),
    .stat_drop_count   (stat_drop_count)
`endif
  );

  always #5 local_clk = ~local_clk;

  logic [FW-1:0] fifo_q[$];
  logic [DW-1:0] exp_hdr[$];
  logic [DW:0]   exp_out[$];
  logic [DW-1:0] pl_q[$];

  int   n_total = 0;
  int   n_bad   = 0;
  int   err_seen = 0;
  int   err_exp  = 0;
  bit   rand_empty = 1'b0;
  bit   rand_ready = 1'b0;
  bit   force_stall = 1'b0;
  bit   prev_hold = 1'b0;
  logic [DW:0] prev_word = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Queue a packet (header + pl_q payload) in the FIFO model and its expected outputs.
  task automatic push_pkt(input logic [DW-1:0] hdr);
    int   n;
    logic lst;
    n = pl_q.size();
    fifo_q.push_back({1'(n == 0), hdr});
    exp_hdr.push_back(hdr);
    for (int i = 0; i < n; i++) begin
      lst = 1'(i == n - 1);
      fifo_q.push_back({lst, pl_q[i]});
      if (i < MAXP) exp_out.push_back({lst | 1'(i == MAXP - 1), pl_q[i]});
    end
    if (n > MAXP) err_exp++;
    pl_q.delete();
  endtask

  // One clock: drive inputs at negedge, sample and score #1 later.
  task automatic step();
    @(negedge local_clk);
    egress_empty      = (fifo_q.size() == 0) || (rand_empty && ($urandom_range(0, 2) == 0));
    egress_data       = (fifo_q.size() != 0) ? fifo_q[0] : FW'($urandom);
    egress_fifo_level = (fifo_q.size() > 32) ? 6'd32 : 6'(fifo_q.size());
    out_ready         = force_stall ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    #1;
    if (egress_empty) chk("rd_empty", 64'(egress_read), 64'd0);
    if (egress_read && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (hdr_valid) begin
      if (exp_hdr.size() == 0) chk("hdr_extra", 64'(hdr_data), 64'hDEAD);
      else chk("hdr", 64'(hdr_data), 64'(exp_hdr.pop_front()));
    end
    if (err_overlong) err_seen++;
    if (prev_hold) begin
      chk("hold_v", 64'(out_valid), 64'd1);
      chk("hold_d", 64'({out_last, out_data}), 64'(prev_word));
    end
    if (out_valid && out_ready) begin
      if (exp_out.size() == 0) chk("out_extra", 64'({out_last, out_data}), 64'hDEAD);
      else chk("out", 64'({out_last, out_data}), 64'(exp_out.pop_front()));
    end
    prev_hold = out_valid && !out_ready;
    prev_word = {out_last, out_data};
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 5000;
    while ((fifo_q.size() != 0 || exp_hdr.size() != 0 || exp_out.size() != 0) && budget > 0) begin
      step();
      budget--;
    end
    chk({tag, "_timeout"}, 64'(budget == 0), 64'd0);
    repeat (4) step();
    chk({tag, "_err"}, 64'(err_seen), 64'(err_exp));
  endtask

  task automatic wait_out_valid(input string tag);
    int b;
    b = 0;
    while (!out_valid && b < 20) begin
      step();
      b++;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    local_arst_n      = 1'b0;
    egress_empty      = 1'b1;
    egress_data       = '0;
    egress_fifo_level = '0;
    out_ready         = 1'b0;
    repeat (3) @(negedge local_clk);
    #1;
    chk("rst_hdr_valid", 64'(hdr_valid), 64'd0);
    chk("rst_hdr_data", 64'(hdr_data), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_err", 64'(err_overlong), 64'd0);
    chk("rst_read", 64'(egress_read), 64'd0);
    @(negedge local_clk);
    local_arst_n = 1'b1;

    // Basic packet: header + two payload flits.
    pl_q = '{32'h11, 32'h22};
    push_pkt(32'h0000_0A01);
    drain("t1");

    // Header-only packet, then a following packet whose first flit is a header.
    push_pkt(32'h0000_BEEF);
    pl_q = '{32'h33};
    push_pkt(32'h0000_CAFE);
    drain("t2");

    // Overlong packet: 6 payload flits truncated to 4.
    pl_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
    push_pkt(32'h0000_0003);
    drain("t3");

    // Backpressure: out_ready low for 5 cycles during a payload.
    pl_q = '{32'hA1, 32'hA2, 32'hA3};
    push_pkt(32'h0000_0004);
    force_stall = 1'b1;
    wait_out_valid("t4");
    repeat (5) begin
      step();
      chk("t4_stall_rd", 64'(egress_read), 64'd0);
      chk("t4_stall_d", 64'(out_data), 64'hA1);
    end
    force_stall = 1'b0;
    drain("t4");

    // Random gaps and backpressure over many short packets, then some overlong ones.
    rand_empty = 1'b1;
    rand_ready = 1'b1;
    for (int p = 0; p < 200; p++) begin
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) pl_q.push_back($urandom);
      push_pkt($urandom);
    end
    drain("t5");
    for (int p = 0; p < 30; p++) begin
      n = $urandom_range(0, 7);
      for (int k = 0; k < n; k++) pl_q.push_back($urandom);
      push_pkt($urandom);
    end
    drain("t5b");
    rand_empty = 1'b0;
    rand_ready = 1'b0;

    // Reset in the middle of a payload.
    pl_q = '{32'hB1, 32'hB2, 32'hB3};
    push_pkt(32'h0000_0006);
    wait_out_valid("t6");
    #2;
    local_arst_n = 1'b0;
    #1;
    chk("t6_hdr_valid", 64'(hdr_valid), 64'd0);
    chk("t6_hdr_data", 64'(hdr_data), 64'd0);
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_out_data", 64'(out_data), 64'd0);
    chk("t6_out_last", 64'(out_last), 64'd0);
    chk("t6_err", 64'(err_overlong), 64'd0);
    chk("t6_read", 64'(egress_read), 64'd0);
    fifo_q.delete();
    exp_hdr.delete();
    exp_out.delete();
    prev_hold = 1'b0;
    egress_empty = 1'b1;
    repeat (2) @(negedge local_clk);
    local_arst_n = 1'b1;
    pl_q = '{32'hC1};
    push_pkt(32'h0000_0007);
    drain("t6");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
